game_controller: RTL and testbench

//  Parametrised game-state sequencer replacing the fixed score/lives logic under the top level.

---
 rtl/game_controller_if.sv | 29 ++
 rtl/game_controller.sv | 110 +++++++++++
 tb/tb_game_controller.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/game_controller_if.sv
// game_controller_if: event inputs and registered status outputs of the game sequencer.
interface game_controller_if #(
  parameter int LIVES_W = 2,
  parameter int SCORE_W = 7,
  parameter int INV_W   = 6,
  parameter int LEVEL_W = 3
);
  logic               frame;
  logic               start;
  logic               invader_collision;
  logic               player_collision;
  logic               invaders_landed;
  logic [2:0]         state;
  logic [LIVES_W-1:0] lives;
  logic [SCORE_W-1:0] score;
  logic [LEVEL_W-1:0] level;
  logic [INV_W-1:0]   invaders_left;
  logic               play_en;
  logic               player_visible;
  logic               level_up;
  modport master (
    output frame, start, invader_collision, player_collision, invaders_landed,
    input  state, lives, score, level, invaders_left, play_en, player_visible, level_up
  );
  modport slave (
    input  frame, start, invader_collision, player_collision, invaders_landed,
    output state, lives, score, level, invaders_left, play_en, player_visible, level_up
  );
endinterface

// File: rtl/game_controller.sv
// game_controller: frame-timed game phase sequencer tracking lives, score, level and invaders.
module game_controller #(
  parameter int LIVES_INIT     = 3,
  parameter int LIVES_W        = 2,
  parameter int SCORE_W        = 7,
  parameter int SCORE_MAX      = 99,
  parameter int PTS_PER_KILL   = 1,
  parameter int NUM_INVADERS   = 55,
  parameter int INV_W          = 6,
  parameter int LEVEL_W        = 3,
  parameter int RESPAWN_FRAMES = 120,
  parameter int CLEAR_FRAMES   = 60
) (
  input logic clk,
  input logic arst,
  game_controller_if.slave bus
);
  localparam int MAXF = RESPAWN_FRAMES > CLEAR_FRAMES ? RESPAWN_FRAMES : CLEAR_FRAMES;
  localparam int CW = $clog2(MAXF) > 8 ? $clog2(MAXF) : 8;
  typedef enum logic [2:0] {IDLE, PLAY, RESPAWN, LEVEL_CLEAR, GAME_OVER} state_t;
  state_t st;
  logic [CW-1:0] cnt, cnt_inc;
  logic start_q, start_rise;
  logic [INV_W-1:0] left_nxt;
  logic [SCORE_W-1:0] score_nxt;
  assign bus.state = st;
  always_comb begin
    start_rise = bus.start & ~start_q;
    cnt_inc = cnt + CW'(1);
    left_nxt = bus.invaders_left - INV_W'(bus.invader_collision && bus.invaders_left != '0);
    score_nxt = !bus.invader_collision ? bus.score :
                (int'(bus.score) + PTS_PER_KILL >= SCORE_MAX) ? SCORE_W'(SCORE_MAX) :
                bus.score + SCORE_W'(PTS_PER_KILL);
  end
  always_ff @(posedge clk or negedge arst)
    if (!arst) begin
      st <= IDLE;
      cnt <= '0;
      start_q <= 1'b0;
      bus.lives <= LIVES_W'(LIVES_INIT);
      bus.score <= '0;
      bus.level <= '0;
      bus.invaders_left <= INV_W'(NUM_INVADERS);
      bus.play_en <= 1'b0;
      bus.player_visible <= 1'b1;
      bus.level_up <= 1'b0;
    end else begin
      start_q <= bus.start;
      bus.level_up <= 1'b0;
      case (st)
        IDLE: if (start_rise) begin
          st <= PLAY;
          bus.play_en <= 1'b1;
        end
        PLAY: begin
          // kills always land, even when a death transition wins the same cycle
          bus.score <= score_nxt;
          bus.invaders_left <= left_nxt;
          if (bus.invaders_landed) begin
            bus.lives <= '0;
            st <= GAME_OVER;
            bus.play_en <= 1'b0;
            bus.player_visible <= 1'b0;
          end else if (bus.player_collision) begin
            bus.lives <= bus.lives - LIVES_W'(1);
            cnt <= '0;
            bus.play_en <= 1'b0;
            st <= bus.lives == LIVES_W'(1) ? GAME_OVER : RESPAWN;
            bus.player_visible <= bus.lives != LIVES_W'(1);
          end else if (left_nxt == '0) begin
            st <= LEVEL_CLEAR;
            cnt <= '0;
            bus.play_en <= 1'b0;
          end
        end
        RESPAWN: if (bus.frame) begin
          if (cnt == CW'(RESPAWN_FRAMES - 1)) begin
            st <= bus.invaders_left == '0 ? LEVEL_CLEAR : PLAY;
            bus.play_en <= bus.invaders_left != '0;
            bus.player_visible <= 1'b1;
            cnt <= '0;
          end else begin
            cnt <= cnt_inc;
            bus.player_visible <= ~cnt_inc[3];
          end
        end
        LEVEL_CLEAR: if (bus.frame) begin
          if (cnt == CW'(CLEAR_FRAMES - 1)) begin
            bus.level <= &bus.level ? bus.level : bus.level + LEVEL_W'(1);
            bus.invaders_left <= INV_W'(NUM_INVADERS);
            bus.level_up <= 1'b1;
            bus.play_en <= 1'b1;
            st <= PLAY;
            cnt <= '0;
          end else
            cnt <= cnt_inc;
        end
        GAME_OVER: if (start_rise) begin
          bus.lives <= LIVES_W'(LIVES_INIT);
          bus.score <= '0;
          bus.level <= '0;
          bus.invaders_left <= INV_W'(NUM_INVADERS);
          bus.play_en <= 1'b1;
          bus.player_visible <= 1'b1;
          st <= PLAY;
        end
        default: st <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_game_controller.sv
// tb_game_controller: directed checks of the game sequencer with hand-computed expectations.
module tb_game_controller;
  logic clk = 1'b0;
  logic arst = 1'b1;
  int checks = 0;
  int failures = 0;
  game_controller_if bus ();
  game_controller dut (.clk(clk), .arst(arst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic kill(input int n);
    repeat (n) begin
      bus.invader_collision = 1'b1;
      tick();
      bus.invader_collision = 1'b0;
      tick();
    end
  endtask
  task automatic hit();
    bus.player_collision = 1'b1;
    tick();
    bus.player_collision = 1'b0;
    tick();
  endtask
  task automatic frames(input int n);
    repeat (n) begin
      bus.frame = 1'b1;
      tick();
      bus.frame = 1'b0;
      tick();
    end
  endtask
  task automatic press();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
  endtask
  initial begin
    bus.frame = 1'b0;
    bus.start = 1'b0;
    bus.invader_collision = 1'b0;
    bus.player_collision = 1'b0;
    bus.invaders_landed = 1'b0;
    #3 arst = 1'b0;
    tick();
    tick();
    check("rst_state", bus.state, 0);
    check("rst_lives", bus.lives, 3);
    check("rst_score", bus.score, 0);
    check("rst_level", bus.level, 0);
    check("rst_left", bus.invaders_left, 55);
    check("rst_play_en", bus.play_en, 0);
    check("rst_visible", bus.player_visible, 1);
    check("rst_level_up", bus.level_up, 0);
    arst = 1'b1;
    tick();
    bus.start = 1'b1;
    tick();
    check("start_state", bus.state, 1);
    check("start_play_en", bus.play_en, 1);
    bus.start = 1'b0;
    tick();
    check("start_lives", bus.lives, 3);
    check("start_left", bus.invaders_left, 55);
    kill(54);
    check("w0_score", bus.score, 54);
    check("w0_left", bus.invaders_left, 1);
    check("w0_state", bus.state, 1);
    kill(1);
    check("clear_state", bus.state, 3);
    check("clear_left", bus.invaders_left, 0);
    check("clear_play_en", bus.play_en, 0);
    check("clear_visible", bus.player_visible, 1);
    kill(1);
    check("clear_kill_ignored", bus.score, 55);
    frames(59);
    check("clear_hold", bus.state, 3);
    check("clear_no_pulse", bus.level_up, 0);
    bus.frame = 1'b1;
    tick();
    check("lvl_up_pulse", bus.level_up, 1);
    check("lvl_state", bus.state, 1);
    check("lvl_level", bus.level, 1);
    check("lvl_left", bus.invaders_left, 55);
    bus.frame = 1'b0;
    tick();
    check("lvl_up_drop", bus.level_up, 0);
    kill(44);
    check("w1_score", bus.score, 99);
    check("w1_left", bus.invaders_left, 11);
    kill(1);
    check("score_sat", bus.score, 99);
    check("sat_left", bus.invaders_left, 10);
    hit();
    check("hit1_lives", bus.lives, 2);
    check("hit1_state", bus.state, 2);
    check("hit1_play_en", bus.play_en, 0);
    kill(1);
    hit();
    check("resp_kill_ignored", bus.invaders_left, 10);
    check("resp_hit_ignored", bus.lives, 2);
    frames(8);
    check("blink_off", bus.player_visible, 0);
    frames(8);
    check("blink_on", bus.player_visible, 1);
    frames(103);
    check("resp_hold", bus.state, 2);
    frames(1);
    check("resp_done", bus.state, 1);
    check("resp_play_en", bus.play_en, 1);
    hit();
    check("hit2_lives", bus.lives, 1);
    frames(120);
    check("resp2_done", bus.state, 1);
    hit();
    check("hit3_lives", bus.lives, 0);
    check("over_state", bus.state, 4);
    check("over_visible", bus.player_visible, 0);
    kill(1);
    check("over_frozen", bus.score, 99);
    press();
    check("restart_state", bus.state, 1);
    check("restart_lives", bus.lives, 3);
    check("restart_score", bus.score, 0);
    check("restart_level", bus.level, 0);
    check("restart_left", bus.invaders_left, 55);
    kill(54);
    bus.invader_collision = 1'b1;
    bus.player_collision = 1'b1;
    tick();
    bus.invader_collision = 1'b0;
    bus.player_collision = 1'b0;
    tick();
    check("both_score", bus.score, 55);
    check("both_left", bus.invaders_left, 0);
    check("both_lives", bus.lives, 2);
    check("both_state", bus.state, 2);
    frames(120);
    check("resp_to_clear", bus.state, 3);
    frames(60);
    check("clear2_state", bus.state, 1);
    check("clear2_level", bus.level, 1);
    check("clear2_lives", bus.lives, 2);
    bus.invaders_landed = 1'b1;
    tick();
    bus.invaders_landed = 1'b0;
    tick();
    check("landed_state", bus.state, 4);
    check("landed_lives", bus.lives, 0);
    press();
    hit();
    frames(5);
    check("pre_arst_state", bus.state, 2);
    arst = 1'b0;
    #1;
    check("arst_state", bus.state, 0);
    check("arst_lives", bus.lives, 3);
    check("arst_score", bus.score, 0);
    check("arst_left", bus.invaders_left, 55);
    check("arst_visible", bus.player_visible, 1);
    check("arst_play_en", bus.play_en, 0);
    arst = 1'b1;
    tick();
    tick();
    check("post_arst_idle", bus.state, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
